// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: req_op fields, access sizes, FSM states.
package lsu_pkg;

   localparam int LSU_MEM_BYTES = 1024;

   localparam int OP_STORE    = 3;
   localparam int OP_UNSIGNED = 2;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_e;

   // Misaligned low bits are dropped so the access lands on its natural boundary.
   function automatic logic [1:0] lane_offset(input size_e size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return addr_lo;
         SZ_HALF: return {addr_lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane extract (with sign/zero extension) and store-lane merge.
module lsu_lane
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [4:0]  byte_shift;
   logic [4:0]  half_shift;
   logic [31:0] byte_word;
   logic [31:0] half_word;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Offset 0 is the most significant lane, so the shift distance counts down.
   assign byte_shift = {~offset, 3'b000};
   assign half_shift = {~offset[1], 4'b0000};
   assign byte_word  = rdata >> byte_shift;
   assign half_word  = rdata >> half_shift;
   assign byte_val   = byte_word[7:0];
   assign half_val   = half_word[15:0];

   always_comb begin
      load_data  = rdata;
      merge_data = wdata;
      case (size)
         SZ_BYTE: begin
            load_data  = is_unsigned ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
            merge_data = (rdata & ~(32'h0000_00FF << byte_shift))
                       | ({24'b0, wdata[7:0]} << byte_shift);
         end
         SZ_HALF: begin
            load_data  = is_unsigned ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
            merge_data = (rdata & ~(32'h0000_FFFF << half_shift))
                       | ({16'b0, wdata[15:0]} << half_shift);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write for sub-word stores.
// Optional build macro LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = LSU_MEM_BYTES
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_e      state;
   size_e       size_reg;
   logic        store_reg;
   logic        unsigned_reg;
   logic [1:0]  off_reg;
   logic [31:0] wdata_reg;

   size_e       req_size;
   logic [32:0] req_end;
   logic        out_of_range;
   logic        misaligned;
   logic        reject;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   assign req_size     = size_e'(req_op[1:0]);
   assign req_end      = {1'b0, req_addr} + 33'd4;
   assign out_of_range = req_end > 33'(MEM_BYTES);

`ifdef LSU_ALIGN_CHECK_EN
   assign misaligned = ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign reject = (req_size == SZ_RSVD) || out_of_range || misaligned;

   lsu_lane u_lane (
      .size        (size_reg),
      .offset      (off_reg),
      .is_unsigned (unsigned_reg),
      .rdata       (mem_rdata),
      .wdata       (wdata_reg),
      .load_data   (load_data),
      .merge_data  (merge_data)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= 32'b0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         mem_addr     <= 32'b0;
         mem_wdata    <= 32'b0;
         size_reg     <= SZ_BYTE;
         store_reg    <= 1'b0;
         unsigned_reg <= 1'b0;
         off_reg      <= 2'b00;
         wdata_reg    <= 32'b0;
      end else begin
         // Pulses and response data default low; each state raises what it needs.
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_wdata  <= 32'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready    <= 1'b0;
                  size_reg     <= req_size;
                  store_reg    <= req_op[OP_STORE];
                  unsigned_reg <= req_op[OP_UNSIGNED];
                  off_reg      <= lane_offset(req_size, req_addr[1:0]);
                  wdata_reg    <= req_wdata;
                  if (reject) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_op[OP_STORE] && (req_size == SZ_WORD)) begin
                     state     <= WR;
                     mem_write <= 1'b1;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= req_wdata;
                  end else begin
                     state    <= RD;
                     mem_read <= 1'b1;
                     mem_addr <= {req_addr[31:2], 2'b00};
                  end
               end
            end
            RD: begin
               if (store_reg) begin
                  state     <= WR;
                  mem_write <= 1'b1;
                  mem_wdata <= merge_data;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_data;
               end
            end
            WR: begin
               state      <= RESP;
               resp_valid <= 1'b1;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
